// File: rtl/move_scheduler.sv
// move_scheduler: buffers decoded key moves between the keyboard decoder and the
// game logic. Moves are issued as single-cycle pulses on move_out, with a hold-off
// enforced after each issued move. PLAY/RESET commands take priority over buffered
// directions and flush the FIFO when they are issued.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   key_valid  key_code is valid this cycle
//   key_code   move encoding (NONE/UP/DOWN/LEFT/RIGHT/PLAY/RESET)
//   key_ready  a direction move will be accepted this cycle (FIFO not full)
//   move_out   issued move; NONE except during the single ISSUE cycle
//   busy       issuing, holding off, FIFO non-empty or command pending
//   drop_cnt   saturating count of rejected direction moves
module move_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 5_000_000,
  parameter int unsigned CNT_W       = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [2:0] key_code,
  output logic       key_ready,
  output logic [2:0] move_out,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] MvNone  = 3'd0;
  localparam logic [2:0] MvUp    = 3'd1;
  localparam logic [2:0] MvDown  = 3'd2;
  localparam logic [2:0] MvLeft  = 3'd3;
  localparam logic [2:0] MvRight = 3'd4;
  localparam logic [2:0] MvPlay  = 3'd5;
  localparam logic [2:0] MvReset = 3'd6;

  localparam logic [PtrW:0]    FullCount = DEPTH[PtrW:0];
  localparam logic [CNT_W-1:0] HoldLoad  = HOLD_CYCLES[CNT_W-1:0];

  typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             cmd_pend_q;
  logic [2:0]       cmd_code_q;
  logic [2:0]       move_q;
  logic [7:0]       drop_q;

  logic is_dir;
  logic is_cmd;
  logic full;
  logic flush;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    is_dir = 1'b0;
    is_cmd = 1'b0;
    if (key_valid) begin
      case (key_code)
        MvUp, MvDown, MvLeft, MvRight: is_dir = 1'b1;
        MvPlay, MvReset:               is_cmd = 1'b1;
        default:                       ;
      endcase
    end
  end

  always_comb begin
    // full comes from the registered count, so a pop never frees a slot for a same-cycle push
    full  = (count_q == FullCount);
    flush = (state_q == StIdle) && cmd_pend_q;
    pop   = (state_q == StIdle) && !cmd_pend_q && (count_q != '0);
    push  = is_dir && !full && !flush;
    drop  = is_dir && full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_pend_q <= 1'b0;
      cmd_code_q <= MvNone;
      move_q     <= MvNone;
      drop_q     <= '0;
    end else begin
      // FIFO storage; pointers wrap modulo DEPTH
      if (push) begin
        mem_q[wr_ptr_q] <= key_code;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + (PtrW + 1)'(1);
          2'b01:   count_q <= count_q - (PtrW + 1)'(1);
          default: ;
        endcase
      end

      // A command arriving on the edge that issues the old one becomes the new pending one
      if (is_cmd) begin
        cmd_pend_q <= 1'b1;
        cmd_code_q <= key_code;
      end else if (flush) begin
        cmd_pend_q <= 1'b0;
      end

      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;

      case (state_q)
        StIdle: begin
          if (cmd_pend_q) begin
            move_q  <= cmd_code_q;
            state_q <= StIssue;
          end else if (count_q != '0) begin
            move_q  <= mem_q[rd_ptr_q];
            state_q <= StIssue;
          end
        end
        StIssue: begin
          move_q <= MvNone;
          cnt_q  <= HoldLoad;
          // With a hold of 0 or 1 the single IDLE cycle already provides the spacing
          state_q <= (HOLD_CYCLES <= 1) ? StIdle : StHold;
        end
        StHold: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // IDLE is entered as the counter reaches 1; that IDLE cycle is the last of the hold
          if (cmd_pend_q || (cnt_q <= CNT_W'(2))) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign key_ready = !full;
  assign move_out  = move_q;
  assign busy      = (state_q != StIdle) || (count_q != '0) || cmd_pend_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler. Instance a uses HOLD_CYCLES=3, instance b uses
// DEPTH=4, HOLD_CYCLES=100. Inputs change on the falling edge; outputs are sampled on
// the falling edge after rising edge c, which is called cycle c.
module tb_move_scheduler;

  localparam logic [2:0] KNone  = 3'd0;
  localparam logic [2:0] KUp    = 3'd1;
  localparam logic [2:0] KDown  = 3'd2;
  localparam logic [2:0] KLeft  = 3'd3;
  localparam logic [2:0] KRight = 3'd4;
  localparam logic [2:0] KPlay  = 3'd5;
  localparam logic [2:0] KReset = 3'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, kv_a, kr_a, busy_a;
  logic [2:0] kc_a, mv_a;
  logic [7:0] drop_a;
  logic       rst_b, kv_b, kr_b, busy_b;
  logic [2:0] kc_b, mv_b;
  logic [7:0] drop_b;

  int total = 0;
  int bad   = 0;

  move_scheduler #(.DEPTH(4), .HOLD_CYCLES(3), .CNT_W(23)) dut_a (
    .clk(clk), .rst(rst_a), .key_valid(kv_a), .key_code(kc_a),
    .key_ready(kr_a), .move_out(mv_a), .busy(busy_a), .drop_cnt(drop_a)
  );

  move_scheduler #(.DEPTH(4), .HOLD_CYCLES(100), .CNT_W(23)) dut_b (
    .clk(clk), .rst(rst_b), .key_valid(kv_b), .key_code(kc_b),
    .key_ready(kr_b), .move_out(mv_b), .busy(busy_b), .drop_cnt(drop_b)
  );

  task automatic reset_b;
    @(negedge clk);
    rst_b = 1'b1; kv_b = 1'b0; kc_b = KNone;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
  endtask

  // rst held for 2 edges, then 10 idle cycles at reset values
  task automatic test_reset;
    @(negedge clk);
    rst_a = 1'b1; kv_a = 1'b0; kc_a = KNone;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (mv_a !== KNone || kr_a !== 1'b1 || busy_a !== 1'b0 || drop_a !== 8'd0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: move=%0d ready=%0d busy=%0d drop=%0d, want 0 1 0 0",
                 c, mv_a, kr_a, busy_a, drop_a);
      end
    end
  endtask

  // UP at edge 0, LEFT at edge 1: pulses in cycles 1 and 5, idle from cycle 9
  task automatic test_spacing;
    logic [2:0] exp;
    @(negedge clk);
    kv_a = 1'b1; kc_a = KUp;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 0) kc_a = KLeft;
      else begin kv_a = 1'b0; kc_a = KNone; end
      exp = (c == 1) ? KUp : (c == 5) ? KLeft : KNone;
      total++;
      if (mv_a !== exp) begin
        bad++;
        $display("FAIL spacing_move cycle %0d: got %0d want %0d", c, mv_a, exp);
      end
      if (c >= 9) begin
        total++;
        if (busy_a !== 1'b0) begin
          bad++;
          $display("FAIL spacing_busy cycle %0d: got %0d want 0", c, busy_a);
        end
      end
    end
  endtask

  // DOWN issued in cycle 1; PLAY sampled while in ISSUE, RESET next edge: only RESET issues
  task automatic test_cmd_overwrite;
    logic [2:0] exp;
    @(negedge clk);
    kv_a = 1'b1; kc_a = KDown;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      case (c)
        1:       begin kv_a = 1'b1; kc_a = KPlay;  end
        2:       begin kv_a = 1'b1; kc_a = KReset; end
        default: begin kv_a = 1'b0; kc_a = KNone;  end
      endcase
      exp = (c == 1) ? KDown : (c == 4) ? KReset : KNone;
      total++;
      if (mv_a !== exp) begin
        bad++;
        $display("FAIL cmd_overwrite cycle %0d: got %0d want %0d", c, mv_a, exp);
      end
    end
  endtask

  // 4 UPs (3 left queued), RESET captured mid-HOLD at edge 5: pulse in cycle 7, queue flushed
  task automatic test_cmd_preempt;
    logic [2:0] exp;
    reset_b();
    @(negedge clk);
    kv_b = 1'b1; kc_b = KUp;
    for (int c = 0; c <= 220; c++) begin
      @(negedge clk);
      if (c < 3) begin kv_b = 1'b1; kc_b = KUp; end
      else if (c == 4) begin kv_b = 1'b1; kc_b = KReset; end
      else begin kv_b = 1'b0; kc_b = KNone; end
      exp = (c == 1) ? KUp : (c == 7) ? KReset : KNone;
      total++;
      if (mv_b !== exp) begin
        bad++;
        $display("FAIL preempt_move cycle %0d: got %0d want %0d", c, mv_b, exp);
      end
      if (c == 4 || c == 8) begin
        total++;
        if (busy_b !== 1'b1) begin
          bad++;
          $display("FAIL preempt_busy cycle %0d: got %0d want 1", c, busy_b);
        end
      end
    end
    total++;
    if (busy_b !== 1'b0) begin
      bad++;
      $display("FAIL preempt_flushed: busy got %0d want 0", busy_b);
    end
  endtask

  // 6 RIGHTs into a 4-deep FIFO: 5 accepted, 1 dropped, pulses 101 cycles apart
  task automatic test_overflow;
    logic [2:0] exp;
    reset_b();
    @(negedge clk);
    kv_b = 1'b1; kc_b = KRight;
    for (int c = 0; c <= 520; c++) begin
      @(negedge clk);
      if (c >= 5) begin kv_b = 1'b0; kc_b = KNone; end
      exp = (c == 1 || c == 102 || c == 203 || c == 304 || c == 405) ? KRight : KNone;
      total++;
      if (mv_b !== exp) begin
        bad++;
        $display("FAIL overflow_move cycle %0d: got %0d want %0d", c, mv_b, exp);
      end
      if (c == 3 || c == 4 || c == 5) begin
        total++;
        if (kr_b !== (c == 3)) begin
          bad++;
          $display("FAIL overflow_ready cycle %0d: got %0d want %0d", c, kr_b, (c == 3));
        end
      end
      if (c == 4 || c == 5 || c == 520) begin
        total++;
        if (drop_b !== ((c == 4) ? 8'd0 : 8'd1)) begin
          bad++;
          $display("FAIL overflow_drop cycle %0d: got %0d want %0d", c, drop_b, (c == 4) ? 0 : 1);
        end
      end
    end
  endtask

  // rst at edge 5 during HOLD with 2 DOWNs queued: reset values, no later pulses
  task automatic test_reset_in_hold;
    logic [2:0] exp;
    reset_b();
    @(negedge clk);
    kv_b = 1'b1; kc_b = KDown;
    for (int c = 0; c <= 260; c++) begin
      @(negedge clk);
      rst_b = (c == 4);
      if (c < 2) begin kv_b = 1'b1; kc_b = KDown; end
      else begin kv_b = 1'b0; kc_b = KNone; end
      exp = (c == 1) ? KDown : KNone;
      total++;
      if (mv_b !== exp) begin
        bad++;
        $display("FAIL hold_reset_move cycle %0d: got %0d want %0d", c, mv_b, exp);
      end
      if (c == 4) begin
        total++;
        if (busy_b !== 1'b1) begin
          bad++;
          $display("FAIL hold_reset_prebusy: got %0d want 1", busy_b);
        end
      end
      if (c >= 5) begin
        total++;
        if (kr_b !== 1'b1 || busy_b !== 1'b0 || drop_b !== 8'd0) begin
          bad++;
          $display("FAIL hold_reset_state cycle %0d: ready=%0d busy=%0d drop=%0d, want 1 0 0",
                   c, kr_b, busy_b, drop_b);
        end
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; kv_a = 1'b0; kc_a = KNone;
    rst_b = 1'b1; kv_b = 1'b0; kc_b = KNone;
    test_reset();
    test_spacing();
    test_cmd_overwrite();
    test_cmd_preempt();
    test_overflow();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
